// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART command decoder driving watch buttons, modes and echo responses
//
// Purpose: decodes single-byte commands from a UART receiver into timed button
// pulses and toggled mode levels, and queues one response byte per command for
// the UART transmitter.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   rx_data     received byte, valid while rx_done=1
//   rx_done     one-cycle received-byte strobe
//   tx_busy     transmitter busy (rises the cycle after tx_start)
//   btnL/R/U/D  button pulses, PULSE_CYCLES long, at most one high
//   fmt_mode    mode level toggled by 'F'/'f'
//   stpw_mode   mode level toggled by 'S'/'s'
//   calib_mode  mode level toggled by 'C'/'c'
//   tx_start    one-cycle send request
//   tx_data     response byte, held until the next pop
module uart_cmd_decoder #(
  parameter int PULSE_CYCLES = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       btnL,
  output logic       btnR,
  output logic       btnU,
  output logic       btnD,
  output logic       fmt_mode,
  output logic       stpw_mode,
  output logic       calib_mode,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, PULSE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] sel, sel_nxt;

  logic       is_btn, is_mode;
  logic [1:0] btn_code, mode_code;
  logic [7:0] resp;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  // Command decode: btn_code 0..3 = L,R,U,D; mode_code 0..2 = F,S,C
  always_comb begin
    is_btn    = 1'b0;
    is_mode   = 1'b0;
    btn_code  = 2'd0;
    mode_code = 2'd0;
    case (rx_data)
      8'h4C, 8'h6C: begin is_btn  = 1'b1; btn_code  = 2'd0; end
      8'h52, 8'h72: begin is_btn  = 1'b1; btn_code  = 2'd1; end
      8'h55, 8'h75: begin is_btn  = 1'b1; btn_code  = 2'd2; end
      8'h44, 8'h64: begin is_btn  = 1'b1; btn_code  = 2'd3; end
      8'h46, 8'h66: begin is_mode = 1'b1; mode_code = 2'd0; end
      8'h53, 8'h73: begin is_mode = 1'b1; mode_code = 2'd1; end
      8'h43, 8'h63: begin is_mode = 1'b1; mode_code = 2'd2; end
      default: ;
    endcase
  end

  // Button commands arriving mid-pulse are answered with '!' instead of an echo
  always_comb begin
    resp = 8'h3F;
    if (is_btn && state != IDLE) begin
      resp = 8'h21;
    end else if (is_btn || is_mode) begin
      resp = rx_data;
    end
  end

  // Button sequencer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      sel   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (rx_done && is_btn) begin
          state_nxt = PULSE;
          cnt_nxt   = 8'(PULSE_CYCLES);
          sel_nxt   = btn_code;
        end
      end
      PULSE: begin
        // Leaving on cnt==1 makes the output high for exactly PULSE_CYCLES cycles
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign btnL = (state == PULSE) && (sel == 2'd0);
  assign btnR = (state == PULSE) && (sel == 2'd1);
  assign btnU = (state == PULSE) && (sel == 2'd2);
  assign btnD = (state == PULSE) && (sel == 2'd3);

  // Mode levels toggle independently of the sequencer
  always_ff @(posedge clk) begin
    if (!rst) begin
      fmt_mode   <= 1'b0;
      stpw_mode  <= 1'b0;
      calib_mode <= 1'b0;
    end else if (rx_done && is_mode) begin
      case (mode_code)
        2'd0:    fmt_mode   <= ~fmt_mode;
        2'd1:    stpw_mode  <= ~stpw_mode;
        default: calib_mode <= ~calib_mode;
      endcase
    end
  end

  // Response FIFO; the extra pointer bit separates full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // tx_start in the previous cycle blocks a pop because tx_busy is not yet visible
  assign pop   = !empty && !tx_busy && !tx_start;
  assign push  = rx_done && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= resp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr[AW-1:0]];
      end
      tx_start <= pop;
    end
  end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter PULSE_CYCLES, default 16, giving the button pulse width in clk cycles (legal range 1..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the response FIFO depth (power of two, 2..16).
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port: rx_data  input  8  received byte from the UART receiver; valid only while rx_done=1.
REQ-006 Port: rx_done  input  1  one-cycle strobe marking a received byte.
REQ-007 Port: tx_busy  input  1  UART transmitter busy; the transmitter raises it in the cycle after tx_start.
REQ-008 Port: btnL, btnR, btnU, btnD  output  1 each  synthetic button pulses that feed the watch button inputs.
REQ-009 Port: fmt_mode, stpw_mode, calib_mode  output  1 each  mode levels that feed the watch mode inputs.
REQ-010 Port: tx_start  output  1  one-cycle request to send tx_data.
REQ-011 Port: tx_data  output  8  response byte; stable while tx_start=1.

Function
REQ-012 The command map SHALL be: 'L'/'l' (0x4C/0x6C) selects btnL; 'R'/'r' selects btnR; 'U'/'u' selects btnU; 'D'/'d' selects btnD; 'F'/'f' toggles fmt_mode; 'S'/'s' toggles stpw_mode; 'C'/'c' toggles calib_mode; every other byte is invalid.
REQ-013 Bytes SHALL be decoded only in cycles where rx_done=1; rx_data is ignored otherwise.
REQ-014 Button sequencer: 2-state FSM, IDLE and PULSE, with an 8-bit down-counter and a 2-bit selected-button register.
REQ-015 A button command in IDLE at edge N SHALL load the counter with PULSE_CYCLES and enter PULSE; the selected output is high for exactly PULSE_CYCLES cycles starting after edge N.
REQ-016 In PULSE the counter SHALL decrement each cycle, and the FSM returns to IDLE when it reaches 0; at most one btn output is high at any time.
REQ-017 A button command received while in PULSE SHALL be rejected: no change to the sequencer, and the response byte is '!' (0x21).
REQ-018 A mode command SHALL invert its mode output after the receiving edge, regardless of the sequencer state.
REQ-019 Each accepted command SHALL enqueue an echo of the received byte exactly as received; an invalid byte SHALL enqueue '?' (0x3F).
REQ-020 The enqueue SHALL occur on the same edge as the decode, so the response is visible in the FIFO one cycle after rx_done.
REQ-021 The response FIFO SHALL be FIFO_DEPTH deep, first-in first-out, with $clog2(FIFO_DEPTH)+1-bit pointers so that full and empty are distinguishable.
REQ-022 If the FIFO is full at enqueue and no pop occurs in the same cycle, the response SHALL be dropped, and the command's effect (pulse or toggle) SHALL still apply.
REQ-023 A simultaneous push and pop while full SHALL accept the push; a simultaneous push and pop while empty SHALL NOT pop.
REQ-024 tx_start SHALL be driven from a register and pulse for one cycle only when the FIFO is non-empty, tx_busy=0, and tx_start=0 in the previous cycle.
REQ-025 The pop SHALL occur on the edge that asserts tx_start; tx_data is registered and holds its value until the next pop.
REQ-026 Latency: rx_done at edge N gives the earliest tx_start after edge N+1; back-to-back pops are at least 2 cycles apart.
REQ-027 A new rx_done arriving during a pulse or a transmission SHALL always be decoded; no input byte is lost, only responses may drop per REQ-022.

Reset
REQ-028 While rst=0 at a clock edge: btnL/R/U/D=0, fmt_mode=0, stpw_mode=0, calib_mode=0, tx_start=0, tx_data=0x00, FSM=IDLE, counter=0, FIFO empty.
REQ-029 Reset asserted mid-pulse or mid-queue SHALL abort immediately; queued responses are discarded, and rx_done in a reset cycle is ignored.

Verification (PULSE_CYCLES=4, FIFO_DEPTH=4)
REQ-030 rx 'U' with tx_busy=0 -> btnU=1 for exactly 4 cycles starting the cycle after rx_done, one tx_start with tx_data=0x55, other btn outputs stay 0.
REQ-031 rx 'L' then 'R' 2 cycles later -> btnL pulses 4 cycles, btnR never rises, responses 0x4C then 0x21 in that order.
REQ-032 rx 'f','S','c','F' -> mode outputs toggle after each byte; final state fmt_mode=0, stpw_mode=1, calib_mode=1; four echoes returned in order.
REQ-033 tx_busy held 1, rx 6 bytes 'x','d','s','u','l','r' -> btnD pulses, stpw_mode=1; after tx_busy=0 exactly 4 responses 0x3F,0x64,0x73,0x75 are sent, and 'l' and 'r' are rejected with their responses dropped.
REQ-034 rst=0 asserted during the 2nd cycle of a btnD pulse with 2 responses queued -> all outputs at reset values the next cycle, and no tx_start after release.
